// File: rtl/exe_div_unit_if.sv
// ---------------------------------------------------------------------------
// exe_div_unit_if
// Request/response bundle between the EXE stage and the multi-cycle divider.
//   master (EXE side)    : drives start_i, signed_i, dividend_i, divisor_i,
//                          annul_i; observes quot_o, rem_o, ready_o, stallreq_o
//   slave  (divider side): the mirror image of master
// ---------------------------------------------------------------------------
interface exe_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             annul_i;
    logic [WIDTH-1:0] quot_o;
    logic [WIDTH-1:0] rem_o;
    logic             ready_o;
    logic             stallreq_o;

    modport master (
        output start_i, signed_i, dividend_i, divisor_i, annul_i,
        input  quot_o, rem_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i, annul_i,
        output quot_o, rem_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/exe_div_unit.sv
// ---------------------------------------------------------------------------
// exe_div_unit
// Radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU in the EXE stage.
// Operands are taken on the accept cycle, divided as magnitudes over WIDTH
// cycles, sign-corrected and presented with a one-cycle ready pulse.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus.slave  start_i/signed_i/dividend_i/divisor_i/annul_i in,
//              quot_o/rem_o/ready_o/stallreq_o out
// ---------------------------------------------------------------------------
module exe_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    exe_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        BUSY    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] dvsr_r;
    logic             neg_q_r;
    logic             neg_r_r;

    logic             accept;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quot_nx;

    // Magnitude of a two's complement value; -2^(WIDTH-1) maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic             en);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        if (en && s < 0)
            return $unsigned(-s);
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        if (neg)
            return $unsigned(-s);
        return v;
    endfunction

    assign accept = (state == IDLE) && bus.start_i && !bus.annul_i;

    // One restoring step: the shifted partial remainder is WIDTH+1 bits so
    // divisors above 2^(WIDTH-1) compare correctly. When the trial subtract
    // succeeds the true difference is below the divisor, so WIDTH bits hold it.
    always_comb begin
        shifted = {rem_r, quot_r[WIDTH-1]};
        if (shifted >= {1'b0, dvsr_r}) begin
            rem_nx  = shifted[WIDTH-1:0] - dvsr_r;
            quot_nx = {quot_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx  = shifted[WIDTH-1:0];
            quot_nx = {quot_r[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.annul_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start_i)
                             state_nx = (bus.divisor_i == '0) ? DIVZERO : BUSY;
                BUSY:    if (cnt == LAST_STEP)
                             state_nx = DONE;
                DIVZERO: state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Step counter and the architecturally visible result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            bus.quot_o <= '0;
            bus.rem_o  <= '0;
        end else if (bus.annul_i) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) cnt <= '0;
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        bus.quot_o <= fix_sign(quot_nx, neg_q_r);
                        bus.rem_o  <= fix_sign(rem_nx, neg_r_r);
                    end
                end
                DIVZERO: begin
                    bus.quot_o <= '1;
                    bus.rem_o  <= rem_r;
                end
                default: ;
            endcase
        end
    end

    // Working registers: no reset needed, every field is loaded on accept.
    // For a zero divisor rem_r carries the raw dividend through DIVZERO.
    always_ff @(posedge clk) begin
        if (accept) begin
            quot_r  <= abs_val(bus.dividend_i, bus.signed_i);
            dvsr_r  <= abs_val(bus.divisor_i, bus.signed_i);
            rem_r   <= (bus.divisor_i == '0) ? bus.dividend_i : '0;
            neg_q_r <= bus.signed_i &&
                       (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
            neg_r_r <= bus.signed_i && bus.dividend_i[WIDTH-1];
        end else if (state == BUSY) begin
            rem_r  <= rem_nx;
            quot_r <= quot_nx;
        end
    end

    // A flush in the DONE cycle suppresses the pulse for the squashed op.
    assign bus.ready_o    = (state == DONE) && !bus.annul_i;
    assign bus.stallreq_o = !bus.annul_i &&
                            (accept || state == BUSY || state == DIVZERO);

endmodule

// File: tb/tb_exe_div_unit.sv
// ---------------------------------------------------------------------------
// tb_exe_div_unit
// Randomized and directed bench for exe_div_unit against an arithmetic
// reference model (64-bit integer division with RISC-V divide-by-zero rules).
// ---------------------------------------------------------------------------
module tb_exe_div_unit;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   last_ready;

    exe_div_unit_if #(.WIDTH(WIDTH)) bus ();

    exe_div_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: divide the mathematical integer values in 64 bits, then
    // keep the low 32 bits (so -2^31 / -1 wraps to -2^31).
    function automatic void ref_div(input bit sgn, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] q,
                                    output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            return;
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    // Issue one division in the current cycle (accept cycle T) and follow it
    // to ready_o. With chain=1, start_i is left high through DONE.
    task automatic run_div(input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input bit chain);
        logic [31:0] eq, er;
        int          t0, lat, bad;
        bit          seen;
        ref_div(sgn, a, b, eq, er);
        lat = (b == 32'd0) ? 2 : WIDTH + 1;
        bus.signed_i   = sgn;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.annul_i    = 1'b0;
        bus.start_i    = 1'b1;
        #0;
        t0   = cyc;
        bad  = 0;
        seen = 1'b0;
        check("stall_accept", {31'd0, bus.stallreq_o}, 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                bus.dividend_i = $urandom;
                bus.divisor_i  = $urandom;
                bus.signed_i   = ~sgn;
            end
            if (bus.ready_o) begin
                seen = 1'b1;
                check("latency", cyc - t0, lat);
                check("quot", bus.quot_o, eq);
                check("rem", bus.rem_o, er);
                check("stall_done", {31'd0, bus.stallreq_o}, 32'd0);
                last_ready = cyc;
                if (!chain)
                    bus.start_i = 1'b0;
                break;
            end
            if (bus.stallreq_o !== 1'b1)
                bad++;
        end
        check("ready_seen", {31'd0, seen}, 32'd1);
        check("stall_inflight", bad, 0);
    endtask

    initial begin
        logic [31:0] a, b, qk, rk;
        int          r1, pulses;
        bit          sgn;

        n_checks       = 0;
        n_pass         = 0;
        last_ready     = 0;
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.annul_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quot", bus.quot_o, 32'd0);
        check("rst_rem", bus.rem_o, 32'd0);
        check("rst_ready", {31'd0, bus.ready_o}, 32'd0);
        check("rst_stall", {31'd0, bus.stallreq_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        run_div(1'b0, 32'd100, 32'd7, 1'b0);               @(posedge clk); #1;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);         @(posedge clk); #1;
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);         @(posedge clk); #1;
        run_div(1'b1, 32'h8000_0005, 32'd0, 1'b0);         @(posedge clk); #1;
        run_div(1'b0, 32'd12345, 32'd0, 1'b0);             @(posedge clk); #1;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); @(posedge clk); #1;
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); @(posedge clk); #1;
        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0); @(posedge clk); #1;

        // Annul at T+10: result registers must keep 1000/3 -> 333 r 1
        ref_div(1'b0, 32'd1000, 32'd3, qk, rk);
        run_div(1'b0, 32'd1000, 32'd3, 1'b0);
        @(posedge clk);
        #1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd7;
        bus.start_i    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        #0;
        check("annul_stall_now", {31'd0, bus.stallreq_o}, 32'd0);
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        #0;
        check("annul_idle_stall", {31'd0, bus.stallreq_o}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.ready_o) pulses++;
            @(posedge clk);
            #1;
        end
        check("annul_no_ready", pulses, 0);
        check("annul_quot_kept", bus.quot_o, qk);
        check("annul_rem_kept", bus.rem_o, rk);

        // Back-to-back with start_i held through DONE
        run_div(1'b0, 32'd5000, 32'd9, 1'b1);
        r1             = last_ready;
        bus.signed_i   = 1'b1;
        bus.dividend_i = 32'hFFFF_FC18;
        bus.divisor_i  = 32'd7;
        @(posedge clk);
        #1;
        run_div(1'b1, 32'hFFFF_FC18, 32'd7, 1'b0);
        check("b2b_spacing", last_ready - r1, WIDTH + 2);
        @(posedge clk);
        #1;

        // Random operands, biased towards small, zero and near-boundary values
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(0, 15));
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_div(sgn, a, b, 1'b0);
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a busy division
        bus.signed_i   = 1'b0;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd7;
        bus.start_i    = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_quot", bus.quot_o, 32'd0);
        check("midrst_rem", bus.rem_o, 32'd0);
        check("midrst_ready", {31'd0, bus.ready_o}, 32'd0);
        check("midrst_stall", {31'd0, bus.stallreq_o}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) pulses++;
        end
        check("midrst_no_ready", pulses, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
